// File: rtl/disp_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package disp_pkg;

    // Scan controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_t;

    localparam int unsigned SEG_W = 7;

    // All segments off (active-low).
    localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;

    // Active-low hex glyphs, bit order {g,f,e,d,c,b,a}; entry n is glyph n.
    localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
        7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
        7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
        7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
    };

    // Parameter legality limits.
    localparam int unsigned MIN_TICK_DIV  = 2;
    localparam int unsigned MIN_BLANK_CYC = 1;

endpackage

// File: rtl/disp_scan_ctrl_hex_to_7seg.sv
// Combinational hex nibble to active-low 7-segment decoder.
module hex_to_7seg
    import disp_pkg::*;
(
    input  logic [3:0]       nibble,
    output logic [SEG_W-1:0] seg_c
);

    // Table lookup of the glyph for the nibble.
    always_comb begin
        seg_c = SEG_TABLE[nibble];
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment scan controller with
// per-slot ghost blanking and frame-synchronous double buffering.
// Optional build macro: DISP_LEAD_ZERO_BLANK_EN (suppress leading zeros).
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int unsigned DIGITS    = 4,
    parameter int unsigned TICK_DIV  = 250000,
    parameter int unsigned BLANK_CYC = 1000
) (
    input  logic                  clk_in,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic [DIGITS-1:0]     dp_in,
    output logic [DIGITS-1:0]     an_out,
    output logic [SEG_W-1:0]      seg_out,
    output logic                  dp_out,
    output logic                  frame_done
);

    localparam int unsigned CNT_W = $clog2(TICK_DIV);
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned NIB_W = 4 * DIGITS;

    if (TICK_DIV < MIN_TICK_DIV) begin : g_bad_tick_div
        $error("disp_scan_ctrl: TICK_DIV must be at least 2");
    end
    if ((BLANK_CYC < MIN_BLANK_CYC) || (BLANK_CYC >= TICK_DIV)) begin : g_bad_blank_cyc
        $error("disp_scan_ctrl: BLANK_CYC must satisfy 1 <= BLANK_CYC < TICK_DIV");
    end

    scan_state_t        state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic               wrap_c;
    logic               frame_done_nxt;

    logic [NIB_W-1:0]   pend_nib, pend_nib_nxt;
    logic [DIGITS-1:0]  pend_dp, pend_dp_nxt;
    logic               pend_vld, pend_vld_nxt;
    logic [NIB_W-1:0]   shd_nib, shd_nib_nxt;
    logic [DIGITS-1:0]  shd_dp, shd_dp_nxt;

    logic [3:0]         sel_nib;
    logic               sel_dp;
    logic               sel_blank;
    logic [DIGITS-1:0]  lz_blank;
    logic [SEG_W-1:0]   seg_dec_c;

    logic [DIGITS-1:0]  an_nxt;
    logic [SEG_W-1:0]   seg_nxt;
    logic               dp_nxt;

    // Next-state logic: slot counter, digit index and frame wrap.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        idx_nxt        = idx;
        wrap_c         = 1'b0;
        frame_done_nxt = 1'b0;
        if (!enable) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            idx_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = BLANK;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                end
                BLANK: begin
                    cnt_nxt = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(BLANK_CYC - 1)) begin
                        state_nxt = DRIVE;
                    end
                end
                DRIVE: begin
                    if (cnt == CNT_W'(TICK_DIV - 1)) begin
                        state_nxt = BLANK;
                        cnt_nxt   = '0;
                        if (idx == IDX_W'(DIGITS - 1)) begin
                            idx_nxt        = '0;
                            wrap_c         = 1'b1;
                            frame_done_nxt = 1'b1;
                        end else begin
                            idx_nxt = idx + IDX_W'(1);
                        end
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                end
            endcase
        end
    end

    // Pending/shadow buffer update; shadow only changes at a wrap or while idle.
    always_comb begin
        pend_nib_nxt = pend_nib;
        pend_dp_nxt  = pend_dp;
        pend_vld_nxt = pend_vld;
        shd_nib_nxt  = shd_nib;
        shd_dp_nxt   = shd_dp;
        if (load) begin
            pend_nib_nxt = digits_in;
            pend_dp_nxt  = dp_in;
            pend_vld_nxt = 1'b1;
        end
        if (wrap_c) begin
            if (load) begin
                shd_nib_nxt  = digits_in;
                shd_dp_nxt   = dp_in;
                pend_vld_nxt = 1'b0;
            end else if (pend_vld) begin
                shd_nib_nxt  = pend_nib;
                shd_dp_nxt   = pend_dp;
                pend_vld_nxt = 1'b0;
            end
        end else if ((state == IDLE) && pend_vld) begin
            shd_nib_nxt = pend_nib;
            shd_dp_nxt  = pend_dp;
            if (!load) begin
                pend_vld_nxt = 1'b0;
            end
        end
    end

    // Leading-zero suppression mask computed from the upcoming shadow contents.
    always_comb begin
        lz_blank = '0;
`ifdef DISP_LEAD_ZERO_BLANK_EN
        begin
            logic zero_run;
            zero_run = 1'b1;
            for (int i = DIGITS - 1; i >= 1; i--) begin
                zero_run    = zero_run && (shd_nib_nxt[i*4 +: 4] == 4'h0) && !shd_dp_nxt[i];
                lz_blank[i] = zero_run;
            end
        end
`endif
    end

    // Select the nibble, dp and blank flag of the digit about to be shown.
    always_comb begin
        sel_nib   = '0;
        sel_dp    = 1'b0;
        sel_blank = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_nxt == IDX_W'(i)) begin
                sel_nib   = shd_nib_nxt[i*4 +: 4];
                sel_dp    = shd_dp_nxt[i];
                sel_blank = lz_blank[i];
            end
        end
    end

    hex_to_7seg u_hex_to_7seg (
        .nibble (sel_nib),
        .seg_c  (seg_dec_c)
    );

    // Output drive values, registered alongside the state.
    always_comb begin
        an_nxt  = '1;
        seg_nxt = SEG_OFF;
        dp_nxt  = 1'b1;
        if ((state_nxt == DRIVE) && !sel_blank) begin
            for (int i = 0; i < DIGITS; i++) begin
                an_nxt[i] = (idx_nxt != IDX_W'(i));
            end
            seg_nxt = seg_dec_c;
            dp_nxt  = !sel_dp;
        end
    end

    // Scan state, counters and output registers.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            an_out     <= '1;
            seg_out    <= SEG_OFF;
            dp_out     <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            an_out     <= an_nxt;
            seg_out    <= seg_nxt;
            dp_out     <= dp_nxt;
            frame_done <= frame_done_nxt;
        end
    end

    // Digit data buffers.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            pend_nib <= '0;
            pend_dp  <= '0;
            pend_vld <= 1'b0;
            shd_nib  <= '0;
            shd_dp   <= '0;
        end else begin
            pend_nib <= pend_nib_nxt;
            pend_dp  <= pend_dp_nxt;
            pend_vld <= pend_vld_nxt;
            shd_nib  <= shd_nib_nxt;
            shd_dp   <= shd_dp_nxt;
        end
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Scoreboard bench for disp_scan_ctrl (DIGITS=4, TICK_DIV=8, BLANK_CYC=2).
// Expected drive slots and frame_done cycles are queued by the stimulus;
// a negedge monitor pops and compares them as the DUT presents them.
module tb_disp_scan_ctrl;

    localparam int unsigned DIGITS    = 4;
    localparam int unsigned TICK_DIV  = 8;
    localparam int unsigned BLANK_CYC = 2;

    typedef struct {
        int         cyc;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        int         len;
    } slot_t;

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  an_out;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic        frame_done;

    int    cyc    = 0;
    int    checks = 0;
    int    errors = 0;
    slot_t slot_q[$];
    int    fd_q[$];

    disp_scan_ctrl #(
        .DIGITS    (DIGITS),
        .TICK_DIV  (TICK_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .enable     (enable),
        .load       (load),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .an_out     (an_out),
        .seg_out    (seg_out),
        .dp_out     (dp_out),
        .frame_done (frame_done)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Hand-written active-low glyphs {g,f,e,d,c,b,a}.
    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    task automatic push_slot(input int c, input int s, input logic [3:0] nib,
                             input logic dpr, input int len);
        slot_t r;
        r.cyc = c;
        r.an  = ~(4'(1) << s);
        r.seg = glyph(nib);
        r.dp  = ~dpr;
        r.len = len;
        slot_q.push_back(r);
    endtask

    // Queue the driven slots of a full frame whose slot-0 blank begins at edge kf.
    task automatic push_frame(input int kf, input logic [15:0] v, input logic [3:0] dp,
                              input logic [3:0] drv);
        logic [3:0] nib;
        for (int s = 0; s < 4; s++) begin
            if (drv[s]) begin
                nib = v[s*4 +: 4];
                push_slot(kf + 8*s + 2, s, nib, dp[s], 6);
            end
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares each drive run and each frame_done pulse against the queues.
    slot_t      cur;
    int         run_len  = 0;
    int         len_exp  = -1;
    logic [3:0] prev_an  = 4'hF;
    always @(negedge clk_in) begin
        if (rst_n === 1'b1) begin
            if (an_out !== 4'hF && prev_an === 4'hF) begin
                checks++;
                run_len = 1;
                if (slot_q.size() == 0) begin
                    errors++;
                    len_exp = -1;
                    $display("FAIL slot_unexpected: an=%b seg=%b at cyc %0d", an_out, seg_out, cyc);
                end else begin
                    cur = slot_q.pop_front();
                    len_exp = cur.len;
                    if (cyc != cur.cyc || an_out !== cur.an || seg_out !== cur.seg || dp_out !== cur.dp) begin
                        errors++;
                        $display("FAIL slot_start: got cyc=%0d an=%b seg=%b dp=%b, expected cyc=%0d an=%b seg=%b dp=%b",
                                 cyc, an_out, seg_out, dp_out, cur.cyc, cur.an, cur.seg, cur.dp);
                    end
                end
            end else if (an_out !== 4'hF) begin
                run_len++;
            end else if (prev_an !== 4'hF && len_exp >= 0) begin
                checks++;
                if (run_len != len_exp) begin
                    errors++;
                    $display("FAIL slot_len: got %0d cycles, expected %0d (ended cyc %0d)", run_len, len_exp, cyc);
                end
            end
            if (frame_done === 1'b1) begin
                checks++;
                if (fd_q.size() == 0) begin
                    errors++;
                    $display("FAIL frame_done_unexpected: pulse at cyc %0d", cyc);
                end else if (fd_q[0] != cyc) begin
                    errors++;
                    $display("FAIL frame_done_cyc: got %0d expected %0d", cyc, fd_q[0]);
                    void'(fd_q.pop_front());
                end else begin
                    void'(fd_q.pop_front());
                end
            end
            prev_an = an_out;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k, k2, k3;
        rst_n     = 1'b0;
        enable    = 1'b0;
        load      = 1'b0;
        digits_in = '0;
        dp_in     = '0;

        // Reset state.
        repeat (3) step();
        check("reset_an", int'(an_out), 'hF);
        check("reset_seg", int'(seg_out), 'h7F);
        check("reset_dp", int'(dp_out), 1);
        check("reset_frame_done", int'(frame_done), 0);
        rst_n = 1'b1;
        step();

        // Basic scan: load while idle, then enable.
        digits_in = 16'h1234; dp_in = 4'b0000; load = 1'b1;
        step();
        load = 1'b0;
        step();
        k = cyc + 1;
        enable = 1'b1;
        push_frame(k, 16'h1234, 4'b0000, 4'b1111);
        fd_q.push_back(k + 32);

        // Double buffer: load mid-slot 1 shows only from the next frame.
        wait_until(k + 12);
        digits_in = 16'hABCD; load = 1'b1;
        step();
        load = 1'b0;
        fd_q.push_back(k + 64);
        push_slot(k + 34, 0, 4'hD, 1'b0, 6);
        push_slot(k + 42, 1, 4'hC, 1'b0, 6);
        push_slot(k + 50, 2, 4'hB, 1'b0, 2);

        // Enable drop during slot 2 drive: blank at once, no frame_done.
        wait_until(k + 51);
        void'(fd_q.pop_back());
        enable = 1'b0;
        step();
        check("drop_an", int'(an_out), 'hF);
        check("drop_seg", int'(seg_out), 'h7F);
        check("drop_frame_done", int'(frame_done), 0);

        // Re-enable restarts at digit 0.
        wait_until(k + 55);
        k2 = cyc + 1;
        enable = 1'b1;
        push_frame(k2, 16'hABCD, 4'b0000, 4'b1111);
        fd_q.push_back(k2 + 32);

        // Load on the wrap edge goes straight into the new frame.
        wait_until(k2 + 31);
        digits_in = 16'h5678; dp_in = 4'b0101; load = 1'b1;
        push_frame(k2 + 32, 16'h5678, 4'b0101, 4'b1111);
        fd_q.push_back(k2 + 64);
        step();
        load = 1'b0;
        dp_in = 4'b0000;
        wait_until(k2 + 64);
        enable = 1'b0;
        step();
        step();

        // Leading-zero handling.
        digits_in = 16'h0042; dp_in = 4'b0000; load = 1'b1;
        step();
        load = 1'b0;
        step();
        k3 = cyc + 1;
        enable = 1'b1;
`ifdef DISP_LEAD_ZERO_BLANK_EN
        push_frame(k3, 16'h0042, 4'b0000, 4'b0011);
`else
        push_frame(k3, 16'h0042, 4'b0000, 4'b1111);
`endif
        fd_q.push_back(k3 + 32);
        wait_until(k3 + 12);
        digits_in = 16'h0000; dp_in = 4'b0000; load = 1'b1;
        step();
        load = 1'b0;
`ifdef DISP_LEAD_ZERO_BLANK_EN
        push_frame(k3 + 32, 16'h0000, 4'b0000, 4'b0001);
`else
        push_frame(k3 + 32, 16'h0000, 4'b0000, 4'b1111);
`endif
        fd_q.push_back(k3 + 64);
        wait_until(k3 + 44);
        digits_in = 16'h0000; dp_in = 4'b0100; load = 1'b1;
        step();
        load = 1'b0;
        dp_in = 4'b0000;
`ifdef DISP_LEAD_ZERO_BLANK_EN
        push_frame(k3 + 64, 16'h0000, 4'b0100, 4'b0111);
`else
        push_frame(k3 + 64, 16'h0000, 4'b0100, 4'b1111);
`endif
        fd_q.push_back(k3 + 96);
        wait_until(k3 + 96);
        enable = 1'b0;
        repeat (10) step();

        check("slots_outstanding", slot_q.size(), 0);
        check("frame_done_outstanding", fd_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/disp_scan_ctrl.md
# disp_scan_ctrl

Time-multiplexed scan controller for the calculator's common-anode 7-segment display. It runs from the board clock and uses an internal prescaler as a clock enable; no derived clock is used. It steps through `DIGITS` digit slots with a ghost-suppression blank at the start of each slot. Digit data is double-buffered, so a new value only takes effect at a frame boundary and the display never shows a torn frame. It sits between the calculator result/register logic and the board anode/segment pins.

## Interface
- `DIGITS`, default 4: number of digits scanned; index 0 is least significant.
- `TICK_DIV`, default 250000: clock cycles per digit slot; must be at least 2.
- `BLANK_CYC`, default 1000: blank cycles at the start of each slot; must satisfy 1 ≤ `BLANK_CYC` < `TICK_DIV`.
- `clk_in` in, 1: system clock; the only clock in the block.
- `rst_n` in, 1: reset, synchronous and active-low.
- `enable` in, 1: scan enable; low means display off.
- `load` in, 1: one-cycle strobe that captures `digits_in` and `dp_in`.
- `digits_in` in, 4*`DIGITS`: hex nibbles; nibble i drives digit i.
- `dp_in` in, `DIGITS`: decimal-point request per digit, active-high.
- `an_out` out, `DIGITS`: anode drives, active-low.
- `seg_out` out, 7: segments {g,f,e,d,c,b,a}, active-low.
- `dp_out` out, 1: decimal point, active-low.
- `frame_done` out, 1: one-cycle pulse at the end of each frame.

## Operation
- **State machine (3 states):**
  - IDLE → BLANK when `enable`=1.
  - BLANK → DRIVE when the slot counter reaches `BLANK_CYC`-1.
  - DRIVE → BLANK when the slot counter reaches `TICK_DIV`-1; the counter clears and the digit index advances.
  - Any state → IDLE when `enable`=0.
- **Slot counter:** width $clog2(`TICK_DIV`). It counts 0..`TICK_DIV`-1 over BLANK plus DRIVE and is held at 0 in IDLE.
- **Digit index:** width $clog2(`DIGITS`), minimum 1 bit. It increments at each slot end and wraps from `DIGITS`-1 to 0. On that wrap `frame_done` pulses for one cycle. The index is forced to 0 in IDLE.
- **Buffering:** two register sets, pending and shadow, for nibbles and dp.
  - `load` writes the pending set and sets `pend_vld`. A second `load` before transfer overwrites the pending set; last value wins.
  - Pending transfers to shadow at the index wrap, or immediately (next edge) when the block is in IDLE.
  - If `load` coincides with the wrap, the incoming value goes straight to shadow.
- **Outputs:** registered, and updated on the same edge as the state.
  - IDLE and BLANK: `an_out` all 1, `seg_out`=7'h7F, `dp_out`=1.
  - DRIVE: `an_out` has bit idx=0 and all others 1; `seg_out` is the hex decode of shadow nibble idx; `dp_out` is the inverse of shadow dp bit idx.
- **Reset:** state IDLE, counter 0, idx 0, shadow and pending cleared, `pend_vld`=0, `an_out` all 1, `seg_out`=7'h7F, `dp_out`=1, `frame_done`=0. Reset mid-scan drops any pending load.

## Timing
- Each slot lasts exactly `TICK_DIV` cycles: `BLANK_CYC` blank cycles, then `TICK_DIV`-`BLANK_CYC` drive cycles.
- A frame lasts `DIGITS`×`TICK_DIV` cycles.
- `enable` 0→1 sampled at edge k: BLANK for slot 0 starts at edge k, and `an_out` bit 0 goes low at edge k+`BLANK_CYC`.
- `enable` 1→0 sampled at edge k: all outputs are inactive from edge k, with no slot completion. `frame_done` does not pulse.
- `load` to visible change: at the next frame wrap, or 1 cycle when the block is IDLE.
- `frame_done` is high on the cycle after the wrap edge.

## Configuration
- Macro `DISP_LEAD_ZERO_BLANK_EN`.
  - Defined: a digit i>0 is blanked when it and all more-significant shadow nibbles are 0. A blanked digit holds its anode at 1 for its whole slot; slot timing is unchanged. Digit 0 is never blanked. A dp request on a blanked digit un-blanks it and all less-significant digits.
  - Undefined: every digit is always driven, including leading zeros.

## Structure
- Package `disp_pkg` holds:
  - the state enum (IDLE, BLANK, DRIVE);
  - the 16-entry active-low 7-segment constant table;
  - the parameter-check constants.
- Sub-module `hex_to_7seg`: a combinational 4-bit to 7-bit active-low decoder, instantiated once on the selected nibble.

## Test plan
Bench uses `DIGITS`=4, `TICK_DIV`=8, `BLANK_CYC`=2.
1. **Reset:** hold `rst_n`=0 for 3 edges → `an_out`=4'b1111, `seg_out`=7'h7F, `dp_out`=1, `frame_done`=0.
2. **Basic scan:** `load` 16'h1234 in IDLE, then `enable`=1 → 2 blank cycles, then `an_out`=4'b1110 with `seg_out`=7'b0011001 ('4') for 6 cycles. Digit 1 follows with `seg_out`=7'b0110000 ('3'). `frame_done` pulses every 32 cycles.
3. **Double buffer:** `load` 16'hABCD mid-slot 1 → digits 2 and 3 still show '2' and '1'. Digit 0 of the next frame shows 7'b0100001 ('d').
4. **Enable drop:** `enable`=0 in DRIVE of slot 2 → next edge `an_out`=4'b1111 and no `frame_done`. Re-enable restarts at digit 0 after 2 blank cycles.
5. **Load on wrap:** `load` on the wrap edge → the new value is shown in slot 0 of the frame that starts on that edge.
6. **Macro defined:** `load` 16'h0042 → anodes 3 and 2 stay 1. Then 16'h0000 → only digit 0 shows '0' (7'b1000000). Then 16'h0000 with dp bit 2 set → digits 2..0 are driven.
